fft_ra2_ctrl: RTL and testbench
===============================

Name: fft_ra2_ctrl

Overview:
Sequencer for the serial radix-2 butterfly engine in an in-place, decimation-in-time FFT. The input is in bit-reversed order in a single data RAM.
- Walks every stage and every butterfly in order.
- Drives RAM read, twiddle ROM and RAM write addresses, and pulses the engine start.
- Gates the RAM write enable, and detects a stalled engine.
- Sits between the top-level FFT start/done handshake and the engine/RAM/ROM datapath.

Parameters:
LOG2N, 4, log2 of FFT length N; N/2 butterflies per stage, LOG2N stages
SW, 3, stage counter width; must satisfy 2^SW >= LOG2N
TIMEOUT, 31, max cycles in WAIT without bf_done before abort with error

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin FFT; sampled only in IDLE
abort  in  1  synchronous cancel of a running FFT
busy  out  1  high from first ISSUE until DONE
done  out  1  one-cycle pulse on normal completion
err  out  1  sticky timeout flag; cleared when start is accepted
stage  out  SW  current stage index
bf_go  out  1  engine start pulse
bf_wren  in  1  engine result-valid strobe (two cycles per butterfly)
bf_done  in  1  engine last-result strobe
rd_addr  out  LOG2N  data RAM read address (RAM read latency 1 cycle)
tw_addr  out  LOG2N-1  twiddle ROM address (ROM latency 1 cycle)
wr_addr  out  LOG2N  data RAM write address
ram_we  out  1  data RAM write enable = bf_wren & busy & state!=DRAIN

Behaviour:
- Reset values: all outputs 0; state IDLE; stage, butterfly index j and wr_sel = 0.
- Engine contract, with bf_go high in relative cycle 0:
  - Engine samples point A and twiddle at end of cycle 1, point B at end of cycle 2.
  - bf_wren high in cycles 8 (result A) and 9 (result B); bf_done high in cycle 9.
  - Engine accepts a new bf_go from cycle 11.
- Index math for stage s and butterfly j (0..N/2-1):
  - half = 1<<s; k = j & (half-1); grp = j >> s.
  - A = (grp << (s+1)) | k; B = A | half.
  - tw = k << (LOG2N-1-s), truncated to LOG2N-1 bits.
- States:
  - IDLE: start=1 -> ISSUE; clear err, stage, j.
  - ISSUE (1 cycle): bf_go=1, rd_addr=A, tw_addr=tw -> FETCHB.
  - FETCHB (1 cycle): rd_addr=B -> WAIT.
  - WAIT: rd_addr holds B. bf_done -> SETTLE. Timeout counter reaching TIMEOUT -> err=1, go to DRAIN.
  - SETTLE (1 cycle): advance j; on j wrap, advance stage. If last butterfly of last stage -> DONE, else -> ISSUE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
  - DRAIN: busy=1, ram_we forced 0; count 11 cycles -> IDLE, with no done pulse.
- Butterfly period is exactly 11 cycles.
- Latency: start seen in cycle 0 -> ISSUE in cycle 1 -> done in cycle 1 + 11*(N/2)*LOG2N. For LOG2N=4 that is cycle 353.
- Write address:
  - wr_addr = wr_sel ? B : A.
  - wr_sel toggles on every cycle with bf_wren=1 while busy; forced to 0 in IDLE and ISSUE.
  - A and B are held unchanged from ISSUE through SETTLE.
- abort:
  - Any state except IDLE, DONE and DRAIN -> DRAIN next cycle.
  - abort in IDLE is ignored.
  - abort coinciding with the final SETTLE: abort wins, so no done pulse.
- start while busy is ignored. start and abort together in IDLE: start wins.
- Async reset mid-FFT: immediate return to IDLE and reset values. No done, err cleared.
- bf_done outside WAIT is ignored. bf_wren while not busy gives ram_we=0.

Decomposition:
- Package fft_ra2_pkg holds:
  - state enum {IDLE, ISSUE, FETCHB, WAIT, SETTLE, DONE, DRAIN};
  - engine timing constants ENG_WR_A=8, ENG_DONE=9, ENG_REARM=11, DRAIN_CYC=11.
- Sub-module fft_ra2_addr_gen: combinational (stage, j) -> (A, B, tw). It is reused by the bench reference model.

Test Plan:
- LOG2N=3, bench engine model, start at cycle 0 -> (A,B,tw) sequence:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - done pulse in cycle 133 only; busy high in cycles 1-132.
- Per butterfly: bf_go at cycle c -> rd_addr=A at c, =B at c+1; ram_we with wr_addr=A at c+8, wr_addr=B at c+9; next bf_go at c+11.
- Engine model withholds bf_done -> err=1 after 31 WAIT cycles, DRAIN for 11 cycles, ram_we=0 throughout DRAIN, no done; a new start clears err.
- abort at cycle 50 -> DRAIN from cycle 51, ram_we suppressed despite engine bf_wren, IDLE at cycle 62, no done; then start runs a full FFT.
- start pulsed at cycles 20 and 40 during a run -> ignored; address sequence and done cycle identical to the first scenario.
- rst_n low at cycle 70 mid-FFT -> all outputs 0 immediately; after release, start gives the nominal sequence from (0,1,0).

Source files
------------

// File: rtl/fft_ra2_pkg.sv
// fft_ra2_pkg: shared definitions for the radix-2 FFT butterfly sequencer.
//   state_t   - sequencer state encoding (legacy-compatible 3-bit codes)
//   ENG_*     - butterfly engine timing, in cycles relative to bf_go
//   DRAIN_CYC - cycles spent letting an in-flight butterfly retire after
//               an abort or timeout
package fft_ra2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    FETCHB = 3'd2,
    WAIT   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5,
    DRAIN  = 3'd6
  } state_t;

  localparam int ENG_WR_A  = 8;   // result A write strobe
  localparam int ENG_DONE  = 9;   // result B write strobe + last-result strobe
  localparam int ENG_REARM = 11;  // earliest cycle the engine takes a new bf_go
  localparam int DRAIN_CYC = 11;

endpackage

// File: rtl/fft_ra2_addr_gen.sv
// fft_ra2_addr_gen: combinational butterfly index math for an in-place
// decimation-in-time radix-2 FFT.
//   stage - stage index s (0..LOG2N-1)
//   j     - butterfly index within the stage (0..N/2-1)
//   a, b  - data RAM addresses of the butterfly's two points (b = a + 2^s)
//   tw    - twiddle ROM address, k << (LOG2N-1-s) with k = j mod 2^s
module fft_ra2_addr_gen #(
  parameter int LOG2N = 4,
  parameter int SW    = 3
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] a,
  output logic [LOG2N-1:0] b,
  output logic [LOG2N-2:0] tw
);

  localparam int TW  = LOG2N - 1;
  localparam int SHW = SW + 1;

  logic [LOG2N-1:0] jx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] k;
  logic [LOG2N-1:0] grp;
  logic [SHW-1:0]   tw_sh;

  assign jx    = {1'b0, j};
  assign half  = LOG2N'(1) << stage;
  assign k     = jx & (half - 1'b1);
  assign grp   = jx >> stage;
  assign a     = (grp << ({1'b0, stage} + 1'b1)) | k;
  assign b     = a | half;
  assign tw_sh = SHW'(LOG2N - 1) - {1'b0, stage};
  // k < 2^s <= 2^(LOG2N-1), so the narrowed k loses nothing.
  assign tw    = TW'(k) << tw_sh;

endmodule

// File: rtl/fft_ra2_ctrl.sv
// fft_ra2_ctrl: sequencer for a serial radix-2 butterfly engine running an
// in-place DIT FFT over a single data RAM holding bit-reversed input.
//   clk, rst_n     - clock, asynchronous active-low reset
//   start, abort   - begin an FFT (IDLE only) / cancel a running FFT
//   busy, done     - run in progress / one-cycle normal-completion pulse
//   err            - sticky engine-timeout flag, cleared on accepted start
//   stage          - current stage index
//   bf_go          - engine start pulse (one per butterfly)
//   bf_wren        - engine result-valid strobe (A then B)
//   bf_done        - engine last-result strobe
//   rd_addr        - data RAM read address (A in ISSUE, B after)
//   tw_addr        - twiddle ROM address for the current butterfly
//   wr_addr        - data RAM write address, follows A/B result order
//   ram_we         - data RAM write enable
module fft_ra2_ctrl
  import fft_ra2_pkg::*;
#(
  parameter int LOG2N   = 4,
  parameter int SW      = 3,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW-1:0]    stage,
  output logic             bf_go,
  input  logic             bf_wren,
  input  logic             bf_done,
  output logic [LOG2N-1:0] rd_addr,
  output logic [LOG2N-2:0] tw_addr,
  output logic [LOG2N-1:0] wr_addr,
  output logic             ram_we
);

  localparam int JW   = LOG2N - 1;
  localparam int NBF  = 1 << JW;
  localparam int CMAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  state_t           state;
  logic [JW-1:0]    j;
  logic             wr_sel;
  logic [CW-1:0]    cnt;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] addr_tw;
  logic             abortable;

  fft_ra2_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .stage (stage),
    .j     (j),
    .a     (addr_a),
    .b     (addr_b),
    .tw    (addr_tw)
  );

  assign abortable = (state == ISSUE) || (state == FETCHB) ||
                     (state == WAIT)  || (state == SETTLE);

  // cnt is shared: WAIT uses it as the engine timeout, DRAIN as its length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stage <= '0;
      j     <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else if (abort && abortable) begin
      state <= DRAIN;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            err   <= 1'b0;
            stage <= '0;
            j     <= '0;
          end
        end
        ISSUE: state <= FETCHB;
        FETCHB: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (bf_done) begin
            state <= SETTLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= DRAIN;
            err   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (j == JW'(NBF - 1)) begin
            j <= '0;
            if (stage == SW'(LOG2N - 1)) begin
              stage <= '0;
              state <= DONE;
            end else begin
              stage <= stage + 1'b1;
              state <= ISSUE;
            end
          end else begin
            j     <= j + 1'b1;
            state <= ISSUE;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          if (cnt == CW'(DRAIN_CYC - 1)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // wr_sel steers wr_addr: first result strobe writes A, second writes B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel <= 1'b0;
    end else if (state == IDLE || state == ISSUE) begin
      wr_sel <= 1'b0;
    end else if (bf_wren && busy) begin
      wr_sel <= ~wr_sel;
    end
  end

  always_comb begin
    rd_addr = '0;
    case (state)
      ISSUE:        rd_addr = addr_a;
      FETCHB, WAIT: rd_addr = addr_b;
      default:      rd_addr = '0;
    endcase
  end

  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);
  assign bf_go   = (state == ISSUE);
  assign tw_addr = addr_tw;
  assign wr_addr = wr_sel ? addr_b : addr_a;
  assign ram_we  = bf_wren && busy && (state != DRAIN);

endmodule

// File: tb/tb_fft_ra2_ctrl.sv
// tb_fft_ra2_ctrl: bench for fft_ra2_ctrl at LOG2N=3.
// Expected outputs are laid out per absolute cycle as a timeline built from
// the butterfly schedule (one butterfly every ENG_REARM cycles, fixed engine
// response offsets); a single negedge process compares the DUT against it.
// A literal table of (A,B,tw) triples and a few literal cycle numbers pin
// the timeline model itself.
module tb_fft_ra2_ctrl;
  import fft_ra2_pkg::*;

  localparam int L     = 3;
  localparam int SWB   = 2;
  localparam int JWB   = L - 1;
  localparam int TO    = 31;
  localparam int NBF   = 1 << (L - 1);
  localparam int NBT   = NBF * L;
  localparam int MAXC  = 1200;
  localparam int NOCUT = 1 << 30;

  logic           clk, rst_n, start, abort;
  logic           busy, done, err, bf_go, bf_wren, bf_done, ram_we;
  logic [SWB-1:0] stage;
  logic [L-1:0]   rd_addr, wr_addr;
  logic [L-2:0]   tw_addr;

  logic [SWB-1:0] ag_stage;
  logic [JWB-1:0] ag_j;
  logic [L-1:0]   ag_a, ag_b;
  logic [L-2:0]   ag_tw;

  fft_ra2_ctrl #(.LOG2N(L), .SW(SWB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .stage(stage),
    .bf_go(bf_go), .bf_wren(bf_wren), .bf_done(bf_done),
    .rd_addr(rd_addr), .tw_addr(tw_addr), .wr_addr(wr_addr), .ram_we(ram_we)
  );

  fft_ra2_addr_gen #(.LOG2N(L), .SW(SWB)) u_ag (
    .stage(ag_stage), .j(ag_j), .a(ag_a), .b(ag_b), .tw(ag_tw)
  );

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_go = -100;
  int last_done = -1;
  int busy_seen = 0;
  int stray_w = -100;
  bit stall = 1'b0;

  int e_busy[MAXC], e_done[MAXC], e_go[MAXC], e_we[MAXC], e_err[MAXC];
  int e_rd[MAXC], e_tw[MAXC], e_wr[MAXC], e_stg[MAXC];

  int lit_a[NBT]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b[NBT]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw[NBT] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Butterfly pair by block arithmetic: blocks of 2*half points, pair
  // distance half, twiddle exponent scaled to the N-point circle.
  task automatic model(input int s, input int jj, output int a, output int b, output int t);
    int half;
    half = 2 ** s;
    a = (jj / half) * 2 * half + (jj % half);
    b = a + half;
    t = (jj % half) * NBF / half;
  endtask

  // Timeline of one FFT whose start is seen in cycle base. Cycles at or
  // beyond cut are left to the caller (drain adds an 11-cycle busy tail).
  // stall_b names a butterfly whose engine never reports done.
  task automatic plan_run(input int base, input int cut, input bit drain, input int stall_b);
    int c, a, b, t, len, b_end;
    for (int n = 0; n < NBT; n++) begin
      if (stall_b >= 0 && n > stall_b) break;
      c = base + 1 + ENG_REARM * n;
      model(n / NBF, n % NBF, a, b, t);
      len   = (n == stall_b) ? 2 + TO : ENG_REARM;
      b_end = (n == stall_b) ? c + 1 + TO : c + ENG_DONE;
      for (int x = c; x < c + len && x < cut; x++) begin
        e_busy[x] = 1;
        if (x == c) begin
          e_go[x] = 1; e_rd[x] = a; e_tw[x] = t; e_stg[x] = n / NBF;
        end else if (x <= b_end) begin
          e_rd[x] = b;
        end
        if (x == c + ENG_WR_A) begin e_we[x] = 1; e_wr[x] = a; end
        if (x == c + ENG_DONE) begin e_we[x] = 1; e_wr[x] = b; end
      end
    end
    if (cut == NOCUT) e_done[base + 1 + ENG_REARM * NBT] = 1;
    else if (drain) for (int x = cut; x < cut + DRAIN_CYC; x++) e_busy[x] = 1;
  endtask

  task automatic set_rst(input int from, input int to);
    for (int x = from; x <= to; x++) begin
      e_rd[x] = 0; e_tw[x] = 0; e_wr[x] = 0; e_stg[x] = 0;
    end
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Engine: responds to every bf_go; optionally withholds bf_done, and can
  // emit stray strobes at stray_w / stray_w+1.
  initial begin
    int d;
    bf_wren = 1'b0;
    bf_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      d = cyc - last_go;
      bf_wren = (d == ENG_WR_A) || (d == ENG_DONE) || (cyc == stray_w) || (cyc == stray_w + 1);
      bf_done = ((d == ENG_DONE) && !stall) || (cyc == stray_w + 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bf_go) last_go = cyc;
      if (done) last_done = cyc;
      if (busy) busy_seen++;
      if (cyc < MAXC) begin
        chk("busy", int'(busy), e_busy[cyc]);
        chk("done", int'(done), e_done[cyc]);
        chk("bf_go", int'(bf_go), e_go[cyc]);
        chk("ram_we", int'(ram_we), e_we[cyc]);
        chk("err", int'(err), e_err[cyc]);
        if (e_rd[cyc] >= 0) chk("rd_addr", int'(rd_addr), e_rd[cyc]);
        if (e_tw[cyc] >= 0) chk("tw_addr", int'(tw_addr), e_tw[cyc]);
        if (e_wr[cyc] >= 0) chk("wr_addr", int'(wr_addr), e_wr[cyc]);
        if (e_stg[cyc] >= 0) chk("stage", int'(stage), e_stg[cyc]);
      end
    end
  end

  initial begin
    int ma, mb, mt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ag_stage = '0; ag_j = '0;

    for (int x = 0; x < MAXC; x++) begin
      e_busy[x] = 0; e_done[x] = 0; e_go[x] = 0; e_we[x] = 0; e_err[x] = 0;
      e_rd[x] = -1; e_tw[x] = -1; e_wr[x] = -1; e_stg[x] = -1;
    end
    set_rst(0, 3);
    plan_run(5, NOCUT, 1'b0, -1);
    plan_run(150, NOCUT, 1'b0, -1);
    plan_run(300, 334, 1'b1, 0);
    for (int x = 334; x <= 360; x++) e_err[x] = 1;
    plan_run(360, 411, 1'b1, -1);
    plan_run(430, NOCUT, 1'b0, -1);
    plan_run(580, 650, 1'b0, -1);
    set_rst(650, 653);
    plan_run(670, NOCUT, 1'b0, -1);
    plan_run(820, NOCUT, 1'b0, -1);
    plan_run(970, 1103, 1'b1, -1);

    for (int i = 0; i < NBT; i++) begin
      model(i / NBF, i % NBF, ma, mb, mt);
      chk("model_a", ma, lit_a[i]);
      chk("model_b", mb, lit_b[i]);
      chk("model_tw", mt, lit_tw[i]);
      ag_stage = SWB'(i / NBF);
      ag_j     = JWB'(i % NBF);
      #1;
      chk("addr_gen_a", int'(ag_a), lit_a[i]);
      chk("addr_gen_b", int'(ag_b), lit_b[i]);
      chk("addr_gen_tw", int'(ag_tw), lit_tw[i]);
    end

    at_cycle(3);   rst_n = 1'b1;

    // nominal run
    at_cycle(5);   start = 1'b1;
    at_cycle(6);   start = 1'b0;
    at_cycle(145);
    chk("lit_done_nominal", last_done, 138);
    chk("lit_busy_cycles", busy_seen, 132);

    // start pulses while busy are ignored
    at_cycle(150); start = 1'b1;
    at_cycle(151); start = 1'b0;
    at_cycle(170); start = 1'b1;
    at_cycle(171); start = 1'b0;
    at_cycle(190); start = 1'b1;
    at_cycle(191); start = 1'b0;
    at_cycle(290);
    chk("lit_done_restart_ignored", last_done, 283);

    // engine stall -> timeout, drain with stray strobes
    at_cycle(300); start = 1'b1; stall = 1'b1; stray_w = 337;
    at_cycle(301); start = 1'b0;
    at_cycle(334);
    chk("lit_err_timeout", int'(err), 1);
    at_cycle(346); stall = 1'b0;
    chk("lit_no_done_timeout", last_done, 283);

    // new start clears err; abort mid-run
    at_cycle(360); start = 1'b1;
    at_cycle(361); start = 1'b0;
    chk("lit_err_cleared", int'(err), 0);
    at_cycle(410); abort = 1'b1;
    at_cycle(411); abort = 1'b0;
    at_cycle(425);
    chk("lit_no_done_abort", last_done, 283);

    // full run after abort
    at_cycle(430); start = 1'b1;
    at_cycle(431); start = 1'b0;
    at_cycle(570);
    chk("lit_done_after_abort", last_done, 563);

    // asynchronous reset mid-run, then a clean run
    at_cycle(580); start = 1'b1;
    at_cycle(581); start = 1'b0;
    at_cycle(650); rst_n = 1'b0;
    at_cycle(653); rst_n = 1'b1;
    at_cycle(670); start = 1'b1;
    at_cycle(671); start = 1'b0;

    // abort in IDLE ignored; start+abort in IDLE -> start wins
    at_cycle(810); abort = 1'b1;
    at_cycle(811); abort = 1'b0;
    at_cycle(820); start = 1'b1; abort = 1'b1;
    at_cycle(821); start = 1'b0; abort = 1'b0;

    // abort on the final SETTLE suppresses done
    at_cycle(970); start = 1'b1;
    at_cycle(971); start = 1'b0;
    at_cycle(1102); abort = 1'b1;
    at_cycle(1103); abort = 1'b0;
    at_cycle(1125);
    chk("lit_done_last_abort", last_done, 953);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
